io_pin_driver: RTL and testbench
================================

// Module: io_pin_driver
// PURPOSE
//  Command-driven stimulus generator for the picoJava-II core's async control pins
//  (pj_irl, pj_nmi, pj_halt, pj_resume, pj_standby). Sits in the sim env beside the core.
//  Sequences each pin event with programmable delay and width, and handshakes against the
//  core's pj_in_halt / pj_standby_out responses so that the pin monitor sees real activity.
// PARAMETERS
//  FIFO_DEPTH   4      command FIFO entries (power of 2, >=2)
//  TIMEOUT_CYC  4096   max cycles to wait for a core response before abort
// PORTS
//  pj_clk          in   1   core clock; all logic on posedge
//  pj_reset        in   1   reset, asynchronous, active-high
//  cmd_valid       in   1   command offered
//  cmd_ready       out  1   FIFO not full; a command is accepted when valid&ready
//  cmd_op          in   3   0 NOP/DELAY, 1 IRL, 2 NMI, 3 HALT, 4 RESUME, 5 STANDBY, 6-7 reserved
//  cmd_arg         in   4   IRL level (op 1 only)
//  cmd_delay       in   16  idle cycles before the assert phase
//  cmd_width       in   16  assert/hold cycles (0 treated as 1)
//  pj_in_halt      in   1   core halt status
//  pj_standby_out  in   1   core standby status
//  pj_irl          out  4   interrupt level
//  pj_nmi          out  1   non-maskable interrupt
//  pj_halt         out  1   halt request
//  pj_resume       out  1   resume request
//  pj_standby      out  1   standby request
//  busy            out  1   sequencer not IDLE or FIFO not empty
//  cmd_done        out  1   1-cycle pulse when a command retires (normal or aborted)
//  timeout_err     out  1   sticky; set on any response timeout
//  done_count      out  16  retired-command count, wraps at 2^16
// BEHAVIOUR
//  Reset: every output 0 except cmd_ready=1; FIFO flushed; FSM to IDLE. Reset asserted
//   mid-command drops all pins to 0 asynchronously; the aborted command is lost.
//  FIFO: push on valid&ready; pop on IDLE->DELAY; simultaneous push/pop when full is
//   disallowed (ready=0 while full). cmd_ready depends on registered full only.
//  FSM: IDLE -> DELAY -> ASSERT -> WAIT_ACK -> HOLD -> RELEASE -> WAIT_REL -> IDLE.
//   IDLE: pop when FIFO non-empty. DELAY: count cmd_delay cycles (0 = skip to ASSERT next cycle).
//   ASSERT: drive pin (IRL: pj_irl=cmd_arg; NMI/HALT/RESUME/STANDBY: pin=1) for one cycle.
//   WAIT_ACK: HALT waits pj_in_halt=1; STANDBY waits pj_standby_out=1; others skip.
//   HOLD: pin held for max(cmd_width,1) cycles counted from ASSERT (IRL, NMI, RESUME, STANDBY);
//    HALT deasserts on the cycle after pj_in_halt is seen (HOLD skipped).
//   RELEASE: drive the pin to 0 (pj_irl=0).
//   WAIT_REL: RESUME waits pj_in_halt=0; STANDBY waits pj_standby_out=0; others skip.
//   cmd_done pulses and done_count increments on the exit to IDLE.
//  Timeout: a counter runs in WAIT_ACK/WAIT_REL; when it reaches TIMEOUT_CYC the pin goes to 0,
//   timeout_err is set (sticky until reset), and the command retires normally via cmd_done.
//  Response already true on entry to WAIT_ACK/WAIT_REL: proceed the next cycle.
//  Pin outputs are registered; at most one pin is active at a time; the pin rises exactly
//   cmd_delay+1 cycles after pop.
//  NOP (op 0) and reserved ops (6-7): DELAY then retire; no pin activity.
//  IRL with arg=0: no visible edge; the command still retires after width.
//  Counters are 16-bit; a delay/width of 16'hFFFF is legal (no overflow).
// STRUCTURE
//  io_pin_pkg: op-code localparams (OP_NOP..OP_STANDBY) and FSM state encoding.
//  Sub-module io_cmd_fifo: FIFO_DEPTH x 39-bit sync FIFO (op,arg,delay,width), full/empty flags.
//  Top: FSM, shared 16-bit phase counter, timeout counter, pin output registers, status.
// TESTING
//  1 IRL arg=4'hA delay=3 width=5 -> pj_irl=A rises 4 cycles after pop, high 5 cycles, then 0;
//    one cmd_done; done_count=1.
//  2 HALT, model raises pj_in_halt 10 cycles later -> pj_halt high 11 cycles, low next cycle;
//    then RESUME width=2 with model dropping pj_in_halt -> 2-cycle resume pulse; done_count=2.
//  3 STANDBY with pj_standby_out tied 0, TIMEOUT_CYC=16 -> pj_standby drops after 16 wait
//    cycles; timeout_err=1 sticky; cmd_done pulses.
//  4 Push FIFO_DEPTH+1 back-to-back NMI width=0 -> cmd_ready=0 while full; each NMI is a
//    1-cycle pulse; all 5 retire in order.
//  5 Assert pj_reset mid-HOLD of an IRL -> pj_irl=0 immediately; busy=0; done_count=0;
//    FIFO empty.

Source files
------------

// File: rtl/io_pin_pkg.sv
// Shared op-codes, FSM encoding and command payload for the picoJava-II pin stimulus driver.
package io_pin_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned ARG_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PIN_W = 8;

    localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [OP_W-1:0] OP_IRL     = 3'd1;
    localparam logic [OP_W-1:0] OP_NMI     = 3'd2;
    localparam logic [OP_W-1:0] OP_HALT    = 3'd3;
    localparam logic [OP_W-1:0] OP_RESUME  = 3'd4;
    localparam logic [OP_W-1:0] OP_STANDBY = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RELEASE  = 3'd5,
        ST_WAIT_REL = 3'd6
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ARG_W-1:0] arg;
        logic [CNT_W-1:0] delay;
        logic [CNT_W-1:0] width;
    } cmd_t;

    // Pin image {irl[3:0], nmi, halt, resume, standby} driven while a command is asserted.
    function automatic logic [PIN_W-1:0] pin_vec(input logic [OP_W-1:0] op,
                                                 input logic [ARG_W-1:0] arg);
        case (op)
            OP_IRL:     pin_vec = {arg, 4'b0000};
            OP_NMI:     pin_vec = 8'b0000_1000;
            OP_HALT:    pin_vec = 8'b0000_0100;
            OP_RESUME:  pin_vec = 8'b0000_0010;
            OP_STANDBY: pin_vec = 8'b0000_0001;
            default:    pin_vec = 8'b0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/io_cmd_fifo.sv
// Small synchronous command FIFO with registered full/empty flags.
module io_cmd_fifo
    import io_pin_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == CW'(0));
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/io_pin_driver.sv
// Command-driven sequencer for the core's async control pins, handshaking on the core's
// halt/standby status so the pin monitor sees realistic activity.
module io_pin_driver
    import io_pin_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        pj_clk,
    input  logic        pj_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_arg,
    input  logic [15:0] cmd_delay,
    input  logic [15:0] cmd_width,
    input  logic        pj_in_halt,
    input  logic        pj_standby_out,
    output logic [3:0]  pj_irl,
    output logic        pj_nmi,
    output logic        pj_halt,
    output logic        pj_resume,
    output logic        pj_standby,
    output logic        busy,
    output logic        cmd_done,
    output logic        timeout_err,
    output logic [15:0] done_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    cmd_t             fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, push_c, pop_c;
    state_t           state_q;
    logic [OP_W-1:0]  op_q;
    logic [ARG_W-1:0] arg_q;
    logic [CNT_W-1:0] width_q, cnt_q, hold_c, cnt_dec_c;
    logic [TW-1:0]    tmo_q;
    logic [PIN_W-1:0] pins_q;
    logic             done_q, err_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic             needs_ack_c, needs_rel_c, pin_op_c, ack_c, rel_c;

    assign fifo_wdata = '{op: cmd_op, arg: cmd_arg, delay: cmd_delay, width: cmd_width};
    assign push_c     = cmd_valid & ~fifo_full;
    assign pop_c      = (state_q == ST_IDLE) & ~fifo_empty;

    io_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (pj_clk),
        .rst_i   (pj_reset),
        .push_i  (push_c),
        .data_i  (fifo_wdata),
        .pop_i   (pop_c),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Per-op handshake selection; hold count is the cycles left after the assert cycle.
    always_comb begin
        needs_ack_c = (op_q == OP_HALT) || (op_q == OP_STANDBY);
        needs_rel_c = (op_q == OP_RESUME) || (op_q == OP_STANDBY);
        pin_op_c    = (op_q != OP_NOP) && (op_q <= OP_STANDBY);
        ack_c       = 1'b1;
        rel_c       = 1'b1;
        if (op_q == OP_HALT)    ack_c = pj_in_halt;
        if (op_q == OP_STANDBY) ack_c = pj_standby_out;
        if (op_q == OP_RESUME)  rel_c = ~pj_in_halt;
        if (op_q == OP_STANDBY) rel_c = ~pj_standby_out;
        hold_c    = (width_q == '0) ? '0 : width_q - CNT_W'(1);
        cnt_dec_c = cnt_q - CNT_W'(cnt_q != '0);
    end

    always_ff @(posedge pj_clk or posedge pj_reset) begin
        if (pj_reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            arg_q      <= '0;
            width_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            pins_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= fifo_rdata.op;
                        arg_q   <= fifo_rdata.arg;
                        width_q <= fifo_rdata.width;
                        cnt_q   <= fifo_rdata.delay;
                        state_q <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (pin_op_c) begin
                        pins_q  <= pin_vec(op_q, arg_q);
                        cnt_q   <= hold_c;
                        state_q <= ST_ASSERT;
                    end else begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                        state_q    <= ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    cnt_q <= cnt_dec_c;
                    tmo_q <= '0;
                    if (needs_ack_c) begin
                        state_q <= ST_WAIT_ACK;
                    end else if (cnt_q == '0) begin
                        pins_q  <= '0;
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_c) begin
                        // HALT releases on the cycle after the core reports halted.
                        if (op_q == OP_HALT || cnt_q == '0) begin
                            pins_q  <= '0;
                            state_q <= ST_RELEASE;
                        end else begin
                            cnt_q   <= cnt_dec_c;
                            state_q <= ST_HOLD;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        pins_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        cnt_q <= cnt_dec_c;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        pins_q  <= '0;
                        state_q <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_dec_c;
                    end
                end
                ST_RELEASE: begin
                    tmo_q <= '0;
                    if (needs_rel_c) begin
                        state_q <= ST_WAIT_REL;
                    end else begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WAIT_REL: begin
                    if (rel_c || tmo_q == TMO_LAST) begin
                        if (!rel_c) err_q <= 1'b1;
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pj_irl      = pins_q[7:4];
    assign pj_nmi      = pins_q[3];
    assign pj_halt     = pins_q[2];
    assign pj_resume   = pins_q[1];
    assign pj_standby  = pins_q[0];
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
    assign cmd_ready   = ~fifo_full;
    assign cmd_done    = done_q;
    assign timeout_err = err_q;
    assign done_count  = done_cnt_q;

endmodule

// File: tb/tb_io_pin_driver.sv
// Self-checking bench for io_pin_driver: directed scenarios plus a randomized command stream
// checked against an expected pin-event list.
module tb_io_pin_driver;

    logic        pj_clk = 1'b0;
    logic        pj_reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_arg = '0;
    logic [15:0] cmd_delay = '0;
    logic [15:0] cmd_width = '0;
    logic        pj_in_halt = 1'b0;
    logic        pj_standby_out = 1'b0;
    logic [3:0]  pj_irl;
    logic        pj_nmi, pj_halt, pj_resume, pj_standby;
    logic        busy, cmd_done, timeout_err;
    logic [15:0] done_count;

    io_pin_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .pj_clk(pj_clk), .pj_reset(pj_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_delay(cmd_delay), .cmd_width(cmd_width),
        .pj_in_halt(pj_in_halt), .pj_standby_out(pj_standby_out),
        .pj_irl(pj_irl), .pj_nmi(pj_nmi), .pj_halt(pj_halt), .pj_resume(pj_resume),
        .pj_standby(pj_standby), .busy(busy), .cmd_done(cmd_done),
        .timeout_err(timeout_err), .done_count(done_count)
    );

    always #5 pj_clk = ~pj_clk;

    typedef struct { logic [7:0] vec; int rise; int width; } ev_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   multi_pin = 0;
    ev_t  evq[$];
    bit   open_ev = 0;
    logic [7:0] open_vec;
    int   open_rise;

    // Pin-activity monitor: one event per contiguous non-zero pin image, after each edge.
    always @(posedge pj_clk) begin
        logic [7:0] cur;
        logic [4:0] kinds;
        #1;
        cyc++;
        cur   = {pj_irl, pj_nmi, pj_halt, pj_resume, pj_standby};
        kinds = {|cur[7:4], cur[3:0]};
        if (cmd_done) done_seen++;
        if ($countones(kinds) > 1) multi_pin++;
        if (pj_reset) begin
            open_ev = 0;
        end else if (!open_ev && cur != 8'h00) begin
            open_ev = 1; open_vec = cur; open_rise = cyc;
        end else if (open_ev && cur == 8'h00) begin
            evq.push_back('{open_vec, open_rise, cyc - open_rise});
            open_ev = 0;
        end else if (open_ev && cur != open_vec) begin
            multi_pin++;
        end
    end

    function automatic ev_t get_ev(int idx);
        ev_t e;
        e.vec = 8'hxx; e.rise = -1; e.width = -1;
        if (idx < evq.size()) e = evq[idx];
        return e;
    endfunction

    task automatic do_reset();
        @(negedge pj_clk);
        pj_reset = 1'b1; cmd_valid = 1'b0; pj_in_halt = 1'b0; pj_standby_out = 1'b0;
        repeat (2) @(negedge pj_clk);
        pj_reset = 1'b0;
    endtask

    // Called and returns on a negedge; acc is the edge index on which the command was taken.
    task automatic push(input logic [2:0] op, input logic [3:0] arg, input logic [15:0] d,
                        input logic [15:0] w, output int acc, output bit ok);
        ok = 0; acc = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_delay = d; cmd_width = w;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready) begin
                acc = cyc + 1; ok = 1;
                @(negedge pj_clk);
                break;
            end
            @(negedge pj_clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pj_clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        pj_reset = 1'b1;
        @(negedge pj_clk);
        obs = {pj_irl, pj_nmi, pj_halt, pj_resume, pj_standby, busy, cmd_done, timeout_err,
               done_count, cmd_ready};
        vectors++;
        if (obs !== 29'h1) begin
            miscompares++; $display("FAIL reset_outputs got=%h exp=%h", obs, 29'h1);
        end
        do_reset();
        @(negedge pj_clk);
        obs = {pj_irl, pj_nmi, pj_halt, pj_resume, pj_standby, busy, cmd_done, timeout_err,
               done_count, cmd_ready};
        vectors++;
        if (obs !== 29'h1) begin
            miscompares++; $display("FAIL post_reset_idle got=%h exp=%h", obs, 29'h1);
        end
    endtask

    task automatic test_irl();
        int acc, base, dbase; bit ok, idle; ev_t e;
        do_reset();
        base = evq.size(); dbase = done_seen;
        push(3'd1, 4'hA, 16'd3, 16'd5, acc, ok);
        wait_idle(idle);
        e = get_ev(base);
        vectors++; if (!(ok && idle)) begin miscompares++; $display("FAIL irl_handshake got=%0d%0d exp=11", ok, idle); end
        vectors++; if (evq.size() - base != 1) begin miscompares++; $display("FAIL irl_events got=%0d exp=1", evq.size() - base); end
        vectors++; if (e.vec !== 8'hA0) begin miscompares++; $display("FAIL irl_value got=%h exp=a0", e.vec); end
        vectors++; if (e.rise != acc + 3 + 2) begin miscompares++; $display("FAIL irl_rise got=%0d exp=%0d", e.rise, acc + 5); end
        vectors++; if (e.width != 5) begin miscompares++; $display("FAIL irl_width got=%0d exp=5", e.width); end
        vectors++; if (done_seen - dbase != 1) begin miscompares++; $display("FAIL irl_done_pulses got=%0d exp=1", done_seen - dbase); end
        vectors++; if (done_count !== 16'd1) begin miscompares++; $display("FAIL irl_done_count got=%0d exp=1", done_count); end
    endtask

    task automatic test_halt_resume();
        int acc, base; bit ok, idle, seen; ev_t e0, e1;
        do_reset();
        base = evq.size();
        push(3'd3, 4'h0, 16'd2, 16'd1, acc, ok);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pj_halt) seen = 1; else @(negedge pj_clk);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL halt_rise got=0 exp=1"); end
        repeat (10) @(negedge pj_clk);
        pj_in_halt = 1'b1;
        wait_idle(idle);
        push(3'd4, 4'h0, 16'd1, 16'd2, acc, ok);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pj_resume) seen = 1; else @(negedge pj_clk);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL resume_rise got=0 exp=1"); end
        repeat (3) @(negedge pj_clk);
        pj_in_halt = 1'b0;
        wait_idle(idle);
        e0 = get_ev(base); e1 = get_ev(base + 1);
        vectors++; if (evq.size() - base != 2) begin miscompares++; $display("FAIL hr_events got=%0d exp=2", evq.size() - base); end
        vectors++; if (e0.vec !== 8'h04 || e0.width != 11) begin miscompares++; $display("FAIL halt_pulse got=%h/%0d exp=04/11", e0.vec, e0.width); end
        vectors++; if (e1.vec !== 8'h02 || e1.width != 2) begin miscompares++; $display("FAIL resume_pulse got=%h/%0d exp=02/2", e1.vec, e1.width); end
        vectors++; if (done_count !== 16'd2 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL hr_status got=%0d/%b exp=2/0", done_count, timeout_err); end
    endtask

    task automatic test_timeout();
        int acc, base, dbase; bit ok, idle; ev_t e;
        do_reset();
        base = evq.size(); dbase = done_seen;
        push(3'd5, 4'h0, 16'd0, 16'd1, acc, ok);
        wait_idle(idle);
        e = get_ev(base);
        vectors++; if (!idle) begin miscompares++; $display("FAIL tmo_idle got=0 exp=1"); end
        vectors++; if (e.vec !== 8'h01 || e.width != 1 + 16) begin miscompares++; $display("FAIL tmo_standby got=%h/%0d exp=01/17", e.vec, e.width); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        vectors++; if (done_seen - dbase != 1 || done_count !== 16'd1) begin miscompares++; $display("FAIL tmo_retire got=%0d/%0d exp=1/1", done_seen - dbase, done_count); end
        push(3'd0, 4'h0, 16'd2, 16'd3, acc, ok);
        wait_idle(idle);
        vectors++; if (timeout_err !== 1'b1 || done_count !== 16'd2) begin miscompares++; $display("FAIL tmo_sticky got=%b/%0d exp=1/2", timeout_err, done_count); end
        vectors++; if (evq.size() - base != 1) begin miscompares++; $display("FAIL nop_no_pin got=%0d exp=1", evq.size() - base); end
    endtask

    task automatic test_back_to_back();
        int acc, base, dbase, nacc; bit ok, idle; logic rdy_after; ev_t e;
        do_reset();
        base = evq.size(); dbase = done_seen; nacc = 0;
        for (int k = 0; k < 5; k++) begin
            push(3'd2, 4'h0, 16'd3, 16'd0, acc, ok);
            if (ok) nacc++;
        end
        rdy_after = cmd_ready;
        vectors++; if (nacc != 5) begin miscompares++; $display("FAIL b2b_accepted got=%0d exp=5", nacc); end
        vectors++; if (rdy_after !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full got=%b exp=0", rdy_after); end
        wait_idle(idle);
        vectors++; if (cmd_ready !== 1'b1 || !idle) begin miscompares++; $display("FAIL b2b_drain got=%b exp=1", cmd_ready); end
        vectors++; if (evq.size() - base != 5) begin miscompares++; $display("FAIL b2b_events got=%0d exp=5", evq.size() - base); end
        for (int k = 0; k < 5; k++) begin
            e = get_ev(base + k);
            vectors++;
            if (e.vec !== 8'h08 || e.width != 1) begin miscompares++; $display("FAIL b2b_nmi%0d got=%h/%0d exp=08/1", k, e.vec, e.width); end
        end
        vectors++; if (done_seen - dbase != 5 || done_count !== 16'd5) begin miscompares++; $display("FAIL b2b_done got=%0d/%0d exp=5/5", done_seen - dbase, done_count); end
    endtask

    task automatic test_random();
        int acc, base, dbase, mbase, n; bit ok, idle;
        logic [7:0] exp_vec[$]; int exp_w[$];
        logic [2:0] op; logic [3:0] arg; int d, w, wm;
        ev_t e;
        do_reset();
        base = evq.size(); dbase = done_seen; mbase = multi_pin; n = 24;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
                0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2;
                3: op = 3'd4; 4: op = 3'd6; default: op = 3'd7;
            endcase
            arg = 4'($urandom);
            d = $urandom_range(0, 4);
            w = $urandom_range(0, 5);
            wm = (w == 0) ? 1 : w;
            push(op, arg, 16'(d), 16'(w), acc, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_push%0d got=0 exp=1", i); end
            if (op == 3'd1 && arg != 4'h0) begin exp_vec.push_back({arg, 4'h0}); exp_w.push_back(wm); end
            if (op == 3'd2) begin exp_vec.push_back(8'h08); exp_w.push_back(wm); end
            if (op == 3'd4) begin exp_vec.push_back(8'h02); exp_w.push_back(wm); end
        end
        wait_idle(idle);
        vectors++; if (evq.size() - base != exp_vec.size()) begin miscompares++; $display("FAIL rnd_events got=%0d exp=%0d", evq.size() - base, exp_vec.size()); end
        for (int k = 0; k < exp_vec.size(); k++) begin
            e = get_ev(base + k);
            vectors++;
            if (e.vec !== exp_vec[k] || e.width != exp_w[k]) begin
                miscompares++; $display("FAIL rnd_ev%0d got=%h/%0d exp=%h/%0d", k, e.vec, e.width, exp_vec[k], exp_w[k]);
            end
        end
        vectors++; if (done_seen - dbase != n || done_count !== 16'(n)) begin miscompares++; $display("FAIL rnd_done got=%0d/%0d exp=%0d", done_seen - dbase, done_count, n); end
        vectors++; if (multi_pin != mbase) begin miscompares++; $display("FAIL rnd_one_pin got=%0d exp=0", multi_pin - mbase); end
    endtask

    task automatic test_reset_mid_hold();
        int acc, base, dbase; bit ok, seen; logic [7:0] pins;
        do_reset();
        push(3'd1, 4'h5, 16'd1, 16'd20, acc, ok);
        push(3'd2, 4'h0, 16'd0, 16'd0, acc, ok);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (pj_irl != 4'h0) seen = 1; else @(negedge pj_clk);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL mid_irl_rise got=0 exp=1"); end
        repeat (3) @(negedge pj_clk);
        pj_reset = 1'b1;
        #1;
        pins = {pj_irl, pj_nmi, pj_halt, pj_resume, pj_standby};
        vectors++; if (pins !== 8'h00) begin miscompares++; $display("FAIL mid_pins_async got=%h exp=00", pins); end
        vectors++; if (busy !== 1'b0 || done_count !== 16'd0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_status got=%b/%0d/%b exp=0/0/1", busy, done_count, cmd_ready); end
        @(negedge pj_clk);
        pj_reset = 1'b0;
        base = evq.size(); dbase = done_seen;
        repeat (30) @(negedge pj_clk);
        vectors++; if (evq.size() != base || done_seen != dbase || busy !== 1'b0) begin miscompares++; $display("FAIL mid_flushed got=%0d/%0d/%b exp=0/0/0", evq.size() - base, done_seen - dbase, busy); end
    endtask

    initial begin
        test_reset();
        test_irl();
        test_halt_resume();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
